// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and issue stage sharing one ALU among NREQ requesters
//
// alu_pkg : data width N and the shared ALU function.
// alu_arbiter ports:
//    clk        in   clock, all state on rising edge
//    rst        in   synchronous active-high reset
//    req_valid  in   [NREQ]    requester i has an operation pending
//    req_ready  out  [NREQ]    one-hot (or zero) accept strobe
//    req_a      in   [NREQ*N]  operand A, requester i at [i*N +: N]
//    req_b      in   [NREQ*N]  operand B, same packing
//    req_op     in   [NREQ*3]  opcode, requester i at [i*3 +: 3]
//    rsp_valid  out  result register is full
//    rsp_ready  in   consumer takes the result this cycle
//    rsp_y      out  [N]       result
//    rsp_id     out  [IW]      index of the requester that issued the result

package alu_pkg;
   parameter int N = 8;

   function automatic logic [N-1:0] alu_eval(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic [2:0]   op);
      logic [N-1:0] y;
      case (op)
         3'd0: y = a + b;
         3'd1: y = a - b;
         3'd2: y = a - 1'b1;
         3'd3: y = a + 1'b1;
         3'd4: y = ~a;
         3'd5: y = a & b;
         3'd6: y = a | b;
         3'd7: y = a ^ b;
      endcase
      return y;
   endfunction
endpackage

module alu_arbiter
   import alu_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*3-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N-1:0]      rsp_y,
   output logic [IW-1:0]     rsp_id
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] grant;
   logic          any_valid;
   logic          can_issue;
   logic          issue;
   logic [N-1:0]  sel_a;
   logic [N-1:0]  sel_b;
   logic [2:0]    sel_op;

   // Circular search starting at ptr; the first valid requester wins.
   always_comb begin
      logic [IW-1:0] idx;
      any_valid = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            grant     = idx;
         end
      end
   end

   // The output register can take a new result when empty or being drained now.
   assign can_issue = !rsp_valid || rsp_ready;
   // Gating with rst keeps req_ready quiet during reset so no request is lost.
   assign issue     = can_issue && any_valid && !rst;

   always_comb begin
      req_ready = '0;
      if (issue) begin
         req_ready[grant] = 1'b1;
      end
   end

   assign sel_a  = req_a[int'(grant)*N +: N];
   assign sel_b  = req_b[int'(grant)*N +: N];
   assign sel_op = req_op[int'(grant)*3 +: 3];

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_id    <= '0;
         ptr       <= '0;
      end else if (issue) begin
         rsp_valid <= 1'b1;
         rsp_y     <= alu_eval(sel_a, sel_b, sel_op);
         rsp_id    <= grant;
         ptr       <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (N=8, NREQ=4)
module tb_alu_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ*3-1:0] req_op;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [W-1:0]      rsp_y;
   logic [1:0]        rsp_id;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_id(rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from the opcode table, in plain integer arithmetic.
   function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
      int r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a - 1;
         3: r = a + 1;
         4: r = 255 - a;
         5: r = a & b;
         6: r = a | b;
         default: r = a ^ b;
      endcase
      return 8'(((r % 256) + 256) % 256);
   endfunction

   // Behavioural model: output register contents and priority pointer.
   bit         m_known = 0;
   bit         m_valid = 0;
   logic [7:0] m_y     = '0;
   int         m_id    = 0;
   int         m_ptr   = 0;

   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] exp_ready;
      g = -1;
      exp_ready = '0;
      if (!rst && (!m_valid || rsp_ready)) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      if (rst || m_known) chk("model_req_ready", req_ready, exp_ready);
      if (m_known) begin
         chk("model_rsp_valid", rsp_valid, m_valid);
         if (m_valid) begin
            chk("model_rsp_y", rsp_y, m_y);
            chk("model_rsp_id", rsp_id, m_id);
         end
      end
      if (rst) begin
         m_known = 1; m_valid = 0; m_y = '0; m_id = 0; m_ptr = 0;
      end else if (m_known) begin
         if (g >= 0) begin
            m_valid = 1;
            m_y     = ref_alu(req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g*3 +: 3]);
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
         end else if (rsp_ready) begin
            m_valid = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
      req_op[i*3 +: 3] = op;
   endtask

   initial begin
      rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
      req_a = '0; req_b = '0; req_op = '0;

      // Reset held two cycles with all requesters valid.
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready, 4'b0000);
         chk("rst_rsp_valid", rsp_valid, 1'b0);
         cyc();
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 4'b0001);
      cyc();

      // Round robin at full rate.
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("rr_rsp_id", rsp_id, j % 4);
         chk("rr_onehot", $onehot(req_ready), 1'b1);
         cyc();
      end

      // Arithmetic wrap on requester 1.
      rst = 1'b1; cyc(); rst = 1'b0;
      req_valid = 4'b0010;
      set_req(1, 8'hF0, 8'h20, 3'd0); cyc();
      set_req(1, 8'h00, 8'h01, 3'd1);
      @(negedge clk); chk("add_wrap_y", rsp_y, 8'h10); chk("add_wrap_id", rsp_id, 1);
      cyc(); set_req(1, 8'hFF, 8'h00, 3'd3);
      @(negedge clk); chk("sub_wrap_y", rsp_y, 8'hFF);
      cyc(); set_req(1, 8'h5A, 8'h00, 3'd4);
      @(negedge clk); chk("inc_wrap_y", rsp_y, 8'h00);
      cyc(); req_valid = 4'b0000;
      @(negedge clk); chk("not_y", rsp_y, 8'hA5);
      cyc();

      // Pointer skip: grant 0 first, then only 0 and 2 valid.
      rst = 1'b1; cyc(); rst = 1'b0;
      req_valid = 4'b0001; cyc();
      req_valid = 4'b0101;
      @(negedge clk); chk("skip_id0", rsp_id, 0); chk("skip_ready0", req_ready, 4'b0100);
      cyc();
      @(negedge clk); chk("skip_id1", rsp_id, 2); chk("skip_ready1", req_ready, 4'b0001);
      cyc();
      @(negedge clk); chk("skip_id2", rsp_id, 0); chk("skip_ready2", req_ready, 4'b0100);
      cyc();
      @(negedge clk); chk("skip_id3", rsp_id, 2);
      req_valid = 4'b0000; cyc();

      // Backpressure with result 0x33 from requester 2 held.
      rst = 1'b1; cyc(); rst = 1'b0;
      req_valid = 4'b0100;
      set_req(2, 8'h30, 8'h03, 3'd6);
      set_req(3, 8'h0F, 8'h01, 3'd0);
      cyc();
      rsp_ready = 1'b0; req_valid = 4'b1111;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1'b1);
         chk("stall_id", rsp_id, 2);
         chk("stall_y", rsp_y, 8'h33);
         chk("stall_ready", req_ready, 4'b0000);
         cyc();
      end
      rsp_ready = 1'b1;
      @(negedge clk); chk("unstall_ready", req_ready, 4'b1000);
      cyc();

      // Reset while stalled.
      rsp_ready = 1'b0; req_valid = 4'b0110; rst = 1'b1;
      @(negedge clk);
      chk("bp_next_id", rsp_id, 3); chk("bp_next_y", rsp_y, 8'h10);
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("rst_stall_valid", rsp_valid, 1'b0);
      chk("rst_stall_y", rsp_y, 8'h00);
      chk("rst_stall_id", rsp_id, 0);
      chk("rst_stall_ready", req_ready, 4'b0010);
      cyc();
      @(negedge clk); chk("rst_stall_grant", rsp_id, 1);
      cyc();

      // Mixed traffic checked by the model alone.
      for (int j = 0; j < 80; j++) begin
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
         end
         cyc();
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and issue controller that shares one combinational ALU (opcodes 0–7, width `N` from `alu_pkg`) among `NREQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. The block grants one request per cycle and registers the result into a one-entry output stage. The result is returned with the requester index over a second valid/ready handshake with backpressure. It sits between the ALU datapath and the client pipelines that need arithmetic/logic service.

## Interface
- `NREQ`, default 4: number of requesters, at least 2. `IW = $clog2(NREQ)`.
- `N`: data width, taken from `alu_pkg`. It is not a local parameter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: bit i means requester i has an operation pending.
- `req_ready`  out  NREQ: bit i means requester i's operation is accepted this cycle. One-hot or zero.
- `req_a`  in  NREQ*N: operand A. Requester i is at `[i*N +: N]`.
- `req_b`  in  NREQ*N: operand B, same packing as `req_a`.
- `req_op`  in  NREQ*3: opcode. Requester i is at `[i*3 +: 3]`.
- `rsp_valid`  out  1: output register holds a result.
- `rsp_ready`  in  1: consumer accepts the result this cycle.
- `rsp_y`  out  N: result.
- `rsp_id`  out  IW: index of the requester that issued the result.

## Operation

**ALU function.** The ALU result is taken modulo 2^N. No carry or flag is produced.
- 0: A+B
- 1: A−B
- 2: A−1
- 3: A+1
- 4: ~A
- 5: A&B
- 6: A|B
- 7: A^B

**Output register states.**
- EMPTY: `rsp_valid`=0.
- FULL: `rsp_valid`=1.

**Issue condition.**
- `can_issue` = !rsp_valid || rsp_ready.
- An issue occurs when `can_issue` is true and any `req_valid` bit is set.

**Transitions.**
- EMPTY→FULL on issue.
- FULL→FULL on issue, when the old result is drained and the new one is loaded in the same cycle.
- FULL→EMPTY when rsp_ready is high and there is no issue.
- FULL holds when rsp_ready is low.

**Arbitration.**
- The priority pointer `ptr` is IW bits wide.
- Grant g is the first i with req_valid[i] set, searching ptr, ptr+1, … NREQ−1, 0, … ptr−1.
- On issue, ptr ← (g+1) mod NREQ. With no issue, ptr holds.

**Handshake on the request side.**
- req_ready[g] = can_issue && req_valid[g]. All other bits are 0.
- req_ready is combinational from req_valid, rsp_valid and rsp_ready. It has no dependency on req_a, req_b or req_op.
- Transfer occurs when req_valid[i] && req_ready[i].
- Requesters hold valid, operands and opcode stable until they are accepted. The arbiter does not rely on requesters dropping valid.

**Loading on issue.** At the next edge:
- rsp_y ← ALU(req_a[g], req_b[g], req_op[g])
- rsp_id ← g
- rsp_valid ← 1

**Stall.** While rsp_valid && !rsp_ready:
- rsp_y and rsp_id are held bit-stable.
- All req_ready bits are 0.
- ptr holds.

## Timing
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, ptr=0.
- req_ready is all-zero while rst is high, regardless of req_valid.
- Latency: a request accepted in cycle t appears on rsp_y in cycle t+1.
- Throughput: 1 operation per cycle while rsp_ready is held high.
- Drain and issue in the same cycle are legal. The output register is reloaded with no bubble.
- Fairness: a continuously valid requester is granted within NREQ issue cycles.
- Reset mid-operation: when rst is high at an edge, any held result and the pointer are discarded. The next cycle shows the reset values. A requester stalled by that cycle's req_ready=0 keeps its request and is served after reset.
- rsp_y and rsp_id are don't-care when rsp_valid=0. They change only on issue or reset.

## Test plan
Tests use N=8 and NREQ=4.
- **Reset:** hold rst high for 2 cycles with req_valid=4'b1111.
  - During reset: req_ready=0 and rsp_valid=0.
  - In the first cycle after release: req_ready=4'b0001. The next cycle shows rsp_id=0.
- **Arithmetic wrap:** requester 1 only.
  - A=0xF0, B=0x20, op=0 → next cycle rsp_y=0x10, rsp_id=1.
  - Then A=0x00, B=0x01, op=1 → rsp_y=0xFF.
  - Then A=0xFF, op=3 → rsp_y=0x00.
  - Then A=0x5A, op=4 → rsp_y=0xA5.
- **Round-robin at full rate:** req_valid=4'b1111 held, rsp_ready=1.
  - rsp_id sequence is 0,1,2,3,0,1 in consecutive cycles.
  - req_ready is one-hot every cycle.
- **Pointer skip:** ptr=1 after one grant to requester 0, then req_valid=4'b0101.
  - Grants go to 2, then 0, then 2.
  - Requesters 1 and 3 are never granted.
- **Backpressure:** result held (rsp_id=2, rsp_y=0x33) with rsp_ready=0 for 3 cycles and req_valid=4'b1111.
  - During the stall: outputs stable and req_ready=0.
  - In the cycle rsp_ready rises: req_ready=4'b1000 and the next result (rsp_id=3) loads at the next edge.
- **Reset while stalled:** rsp_valid=1 and rsp_ready=0, then assert rst for 1 cycle.
  - Next cycle: rsp_valid=0, rsp_y=0, rsp_id=0.
  - After release: first grant goes to the lowest-index valid requester.
